// File: rtl/hb_up2_pkg.sv
// Shared types for the half-band 2x interpolator output serializer.
//   state_e     : output FSM states (idle, even phase, odd phase).
//   pair_t      : one polyphase pair {d0, d1, ovf} at the default sample width;
//                 modules with a different DATA_WIDTH declare the same layout locally.
//   level_width : width of a FIFO occupancy count for a given depth.
package hb_up2_pkg;

    localparam int unsigned DefaultDataWidth = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPh0  = 2'd1,
        StPh1  = 2'd2
    } state_e;

    typedef struct packed {
        logic [DefaultDataWidth-1:0] d0;
        logic [DefaultDataWidth-1:0] d1;
        logic                        ovf;
    } pair_t;

    // Count 0..depth inclusive needs one bit more than the address.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hb_up2_ser_if.sv
// Bus bundle between the interpolator, the serializer and the downstream sink.
//   din_valid/din0/din1/din_ovf : polyphase pair in
//   dout/dout_valid/dout_ready/dout_ovf : serialized stream out with handshake
//   drop, fifo_level, ovf_cnt, ovf_cnt_clr : status and counter control
// master = producer/consumer side (testbench or system), slave = serializer.
interface hb_up2_ser_if
    import hb_up2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned OVF_CNT_WIDTH = 16
);
    localparam int unsigned LevelWidth = level_width(FIFO_DEPTH);

    logic                     din_valid;
    logic [DATA_WIDTH-1:0]    din0;
    logic [DATA_WIDTH-1:0]    din1;
    logic                     din_ovf;
    logic [DATA_WIDTH-1:0]    dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic                     dout_ovf;
    logic                     drop;
    logic [LevelWidth-1:0]    fifo_level;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt;
    logic                     ovf_cnt_clr;

    modport master (
        output din_valid, din0, din1, din_ovf, dout_ready, ovf_cnt_clr,
        input  dout, dout_valid, dout_ovf, drop, fifo_level, ovf_cnt
    );

    modport slave (
        input  din_valid, din0, din1, din_ovf, dout_ready, ovf_cnt_clr,
        output dout, dout_valid, dout_ovf, drop, fifo_level, ovf_cnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers (no spare entry).
//   clk, rst    : clock, synchronous active-high reset
//   push, wdata : write request; accepted when not full, or when full and popping
//   pop         : remove head entry (ignored when empty)
//   full, empty, level : occupancy status
//   rdata       : registered head entry (valid while not empty)
//   rdata_next  : the head entry as it will be after this clock edge; lets the
//                 consumer register the new head in the same edge as a pop or a
//                 write into an empty FIFO
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         rdata,
    output logic [WIDTH-1:0]         rdata_next
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLevel = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      remain;
    logic [WIDTH-1:0] rdata_q;
    logic             push_ok, pop_ok;

    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == FullLevel);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    assign remain   = level - (AW+1)'(pop_ok);

    // If nothing older survives this edge the new head is the incoming word.
    assign rdata_next = (remain == '0) ? wdata : mem_q[rd_ptr_d[AW-1:0]];
    assign rdata      = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdata_q  <= rdata_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/hb_up2_ser.sv
// Serializes polyphase pairs from a 2x half-band interpolator into one stream:
// each pair {din0, din1, din_ovf} is buffered in a pair FIFO and emitted as
// din0 then din1, with the pair's overflow flag on both samples.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hb_up2_ser_if.slave -- pair input, stream output with
//              valid/ready, drop pulse, fifo_level, saturating ovf_cnt and its clear
module hb_up2_ser
    import hb_up2_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned OVF_CNT_WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    hb_up2_ser_if.slave bus
);
    localparam int unsigned LevelWidth = level_width(FIFO_DEPTH);
    localparam int unsigned PairWidth  = 2 * DATA_WIDTH + 1;
    localparam logic [LevelWidth-1:0]    OneLevel = LevelWidth'(1);
    localparam logic [OVF_CNT_WIDTH-1:0] CntOne   = OVF_CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] d0;
        logic [DATA_WIDTH-1:0] d1;
        logic                  ovf;
    } pair_dw_t;

    state_e                   state_q, state_d;
    logic [DATA_WIDTH-1:0]    dout_q, dout_d;
    logic                     dout_valid_q, dout_valid_d;
    logic                     dout_ovf_q, dout_ovf_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    pair_dw_t                 wr_pair, head_q, head_next, head_sel;
    logic                     fifo_full, fifo_empty;
    logic [LevelWidth-1:0]    fifo_level;
    logic                     hs, pop, push_ok;

    assign wr_pair = {bus.din0, bus.din1, bus.din_ovf};
    assign hs      = dout_valid_q && bus.dout_ready;
    // Pair leaves the FIFO only once its odd sample has been accepted.
    assign pop     = (state_q == StPh1) && hs;
    assign push_ok = bus.din_valid && (!fifo_full || pop);

    sync_fifo #(
        .WIDTH (PairWidth),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.din_valid),
        .wdata      (wr_pair),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .rdata      (head_q),
        .rdata_next (head_next)
    );

    // In PH0 the head is stable, so the registered copy supplies din1; every
    // transition into PH0 needs the post-edge head instead.
    assign head_sel = (state_q == StPh0) ? head_q : head_next;

    always_comb begin
        state_d      = state_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_ovf_d   = dout_ovf_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty || push_ok) begin
                    state_d      = StPh0;
                    dout_d       = head_sel.d0;
                    dout_ovf_d   = head_sel.ovf;
                    dout_valid_d = 1'b1;
                end
            end
            StPh0: begin
                if (hs) begin
                    state_d    = StPh1;
                    dout_d     = head_sel.d1;
                    dout_ovf_d = head_sel.ovf;
                end
            end
            StPh1: begin
                if (hs) begin
                    if (fifo_level > OneLevel || push_ok) begin
                        state_d    = StPh0;
                        dout_d     = head_sel.d0;
                        dout_ovf_d = head_sel.ovf;
                    end else begin
                        state_d      = StIdle;
                        dout_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d      = StIdle;
                dout_valid_d = 1'b0;
            end
        endcase
    end

    // Every received pair is either written or dropped, so both count.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (bus.ovf_cnt_clr) begin
            ovf_cnt_d = (bus.din_valid && bus.din_ovf) ? CntOne : '0;
        end else if (bus.din_valid && bus.din_ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_ovf_q   <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_ovf_q   <= dout_ovf_d;
            ovf_cnt_q    <= ovf_cnt_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_ovf   = dout_ovf_q;
    assign bus.fifo_level = fifo_level;
    assign bus.ovf_cnt    = ovf_cnt_q;
    assign bus.drop       = bus.din_valid && fifo_full && !pop && !rst;

endmodule

// File: tb/tb_hb_up2_ser.sv
module tb_hb_up2_ser;
    localparam int unsigned DW = 16;
    localparam int unsigned FD = 4;
    localparam int unsigned OW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hb_up2_ser_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .OVF_CNT_WIDTH(OW)) bus ();

    hb_up2_ser #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .OVF_CNT_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic o, input logic rdy, input logic clr);
        bus.din_valid   = v;
        bus.din0        = a;
        bus.din1        = b;
        bus.din_ovf     = o;
        bus.dout_ready  = rdy;
        bus.ovf_cnt_clr = clr;
    endtask

    task automatic expect_pair(input logic [15:0] a, input logic [15:0] b, input logic o);
        exp_q.push_back({o, a});
        exp_q.push_back({o, b});
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Caller holds dout_ready=1, din_valid=0; waits for the stream to go idle.
    task automatic drain(input int max_cyc);
        bit done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            settle();
            if (!bus.dout_valid) done = 1'b1;
            else adv();
        end
        chk("drain_bound", {31'b0, done}, 32'd1);
        if (done) adv();
    endtask

    // Scoreboard monitor: every accepted sample must match the next expected one.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got dout %0h ovf %0b, required no output",
                         bus.dout, bus.dout_ovf);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream", {15'b0, bus.dout_ovf, bus.dout}, {15'b0, mon_e});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        logic [15:0] c_exp[4];
        int          cnt_exp[5];
        c_exp   = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        cnt_exp = '{1, 2, 3, 3, 3};

        // Reset, with a flagged pair presented that must be ignored.
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0);
        settle();
        chk("rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        chk("rst_dout", {16'b0, bus.dout}, 32'd0);
        chk("rst_dout_ovf", {31'b0, bus.dout_ovf}, 32'd0);
        chk("rst_level", {29'b0, bus.fifo_level}, 32'd0);
        chk("rst_drop", {31'b0, bus.drop}, 32'd0);
        adv();
        settle();
        chk("rst_ovf_cnt", {30'b0, bus.ovf_cnt}, 32'd0);
        chk("rst_level_hold", {29'b0, bus.fifo_level}, 32'd0);
        adv();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("post_rst_valid", {31'b0, bus.dout_valid}, 32'd0);
        adv();

        // Alternate-cycle pairs, continuous output.
        for (int k = 0; k < 3; k++) begin
            a = 16'(2 * k + 1);
            b = 16'(2 * k + 2);
            drive(1'b1, a, b, 1'b0, 1'b1, 1'b0);
            expect_pair(a, b, 1'b0);
            settle();
            chk("a_drop", {31'b0, bus.drop}, 32'd0);
            chk("a_valid", {31'b0, bus.dout_valid}, (k == 0) ? 32'd0 : 32'd1);
            adv();
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
            settle();
            chk("a_valid", {31'b0, bus.dout_valid}, 32'd1);
            chk("a_drop", {31'b0, bus.drop}, 32'd0);
            if (k == 0) chk("a_latency", {16'b0, bus.dout}, 32'd1);
            adv();
        end
        drain(4);

        // Stalled output: FIFO fills, fifth pair dropped.
        for (int k = 0; k < 5; k++) begin
            a = 16'((k + 1) * 16 + 1);
            b = 16'((k + 1) * 16 + 2);
            drive(1'b1, a, b, 1'b0, 1'b0, 1'b0);
            if (k < 4) expect_pair(a, b, 1'b0);
            settle();
            chk("b_drop", {31'b0, bus.drop}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) chk("b_level_full", {29'b0, bus.fifo_level}, 32'd4);
            adv();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("b_drop_once", {31'b0, bus.drop}, 32'd0);
        chk("b_level_hold", {29'b0, bus.fifo_level}, 32'd4);
        chk("b_dout_hold", {16'b0, bus.dout}, 32'h0011);
        adv();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("b_valid", {31'b0, bus.dout_valid}, 32'd1);
            adv();
        end
        settle();
        chk("b_idle_valid", {31'b0, bus.dout_valid}, 32'd0);
        chk("b_idle_level", {29'b0, bus.fifo_level}, 32'd0);
        adv();

        // Ready toggling during one pair holds each sample until accepted.
        drive(1'b1, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b0);
        expect_pair(16'h7FFF, 16'h8000, 1'b0);
        settle();
        adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, (i % 2) == 1, 1'b0);
            settle();
            chk("c_dout", {16'b0, bus.dout}, {16'b0, c_exp[i]});
            chk("c_valid", {31'b0, bus.dout_valid}, 32'd1);
            adv();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("c_idle_valid", {31'b0, bus.dout_valid}, 32'd0);
        adv();

        // Full FIFO, new pair coincides with the PH1 pop.
        for (int k = 0; k < 4; k++) begin
            a = 16'h0A00 + 16'(k);
            b = 16'h0B00 + 16'(k);
            drive(1'b1, a, b, 1'b0, 1'b0, 1'b0);
            expect_pair(a, b, 1'b0);
            settle();
            adv();
        end
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("d_level_full", {29'b0, bus.fifo_level}, 32'd4);
        adv();
        drive(1'b1, 16'h0AEE, 16'h0BEE, 1'b0, 1'b1, 1'b0);
        expect_pair(16'h0AEE, 16'h0BEE, 1'b0);
        settle();
        chk("d_no_drop", {31'b0, bus.drop}, 32'd0);
        adv();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("d_level_after", {29'b0, bus.fifo_level}, 32'd4);
        adv();
        drain(12);

        // Overflow counting with clear coincident with an event.
        for (int k = 0; k < 3; k++) begin
            a = 16'h0E01 + 16'(2 * k);
            b = 16'h0E02 + 16'(2 * k);
            drive(1'b1, a, b, 1'b1, 1'b1, k == 2);
            expect_pair(a, b, 1'b1);
            settle();
            adv();
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
            settle();
            chk("e_ovf_cnt", {30'b0, bus.ovf_cnt}, (k == 2) ? 32'd1 : 32'(k + 1));
            chk("e_dout_ovf", {31'b0, bus.dout_ovf}, 32'd1);
            adv();
        end
        drain(6);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
        settle();
        adv();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("e_clr_alone", {30'b0, bus.ovf_cnt}, 32'd0);
        adv();
        for (int k = 0; k < 5; k++) begin
            a = 16'h0F00 + 16'(2 * k);
            b = 16'h0F01 + 16'(2 * k);
            drive(1'b1, a, b, 1'b1, 1'b1, 1'b0);
            expect_pair(a, b, 1'b1);
            settle();
            adv();
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
            settle();
            chk("e_ovf_sat", {30'b0, bus.ovf_cnt}, 32'(cnt_exp[k]));
            adv();
        end
        drain(6);

        // Reset while in PH1 with two pairs queued.
        drive(1'b1, 16'h0C01, 16'h0C02, 1'b0, 1'b0, 1'b0);
        expect_pair(16'h0C01, 16'h0C02, 1'b0);
        settle();
        adv();
        drive(1'b1, 16'h0C03, 16'h0C04, 1'b0, 1'b0, 1'b0);
        expect_pair(16'h0C03, 16'h0C04, 1'b0);
        settle();
        adv();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("f_level_two", {29'b0, bus.fifo_level}, 32'd2);
        adv();
        drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        settle();
        chk("f_rst_drop", {31'b0, bus.drop}, 32'd0);
        exp_q.delete();
        adv();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("f_valid_after_rst", {31'b0, bus.dout_valid}, 32'd0);
        chk("f_level_after_rst", {29'b0, bus.fifo_level}, 32'd0);
        chk("f_ovf_after_rst", {30'b0, bus.ovf_cnt}, 32'd0);
        adv();
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1, 1'b0);
        expect_pair(16'hAAAA, 16'h5555, 1'b0);
        settle();
        adv();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("f_resume", {16'b0, bus.dout}, 32'hAAAA);
        adv();
        drain(4);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hb_up2_ser.md
HB_UP2_SER -- requirements
Module: hb_up2_ser

Interface
REQ-001 DATA_WIDTH, 16, width of each polyphase sample and of dout.
REQ-002 FIFO_DEPTH, 4, pair-FIFO depth in sample pairs; power of two, >=2.
REQ-003 OVF_CNT_WIDTH, 16, width of the overflow event counter.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 din_valid  in  1  a polyphase pair is present on din0/din1/din_ovf this cycle.
REQ-007 din0  in  DATA_WIDTH  even-phase sample from the 2x half-band interpolator (yout0).
REQ-008 din1  in  DATA_WIDTH  odd-phase sample from the 2x half-band interpolator (yout1).
REQ-009 din_ovf  in  1  interpolator overflow flag for this pair.
REQ-010 dout  out  DATA_WIDTH  serialized sample stream.
REQ-011 dout_valid  out  1  dout holds a valid sample.
REQ-012 dout_ready  in  1  downstream accepts dout when dout_valid and dout_ready are both high.
REQ-013 dout_ovf  out  1  overflow flag of the pair that dout belongs to.
REQ-014 drop  out  1  one-cycle pulse: the incoming pair was discarded because the FIFO was full.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  number of pairs stored, including the pair being output.
REQ-016 ovf_cnt  out  OVF_CNT_WIDTH  saturating count of pairs received with din_ovf=1.
REQ-017 ovf_cnt_clr  in  1  synchronous clear of ovf_cnt.

Function
REQ-018 The block SHALL write {din0, din1, din_ovf} into the pair FIFO on every cycle where din_valid=1 and the FIFO is not full, or where it is full and the head pair is popped in the same cycle.
REQ-019 The output FSM SHALL have states IDLE, PH0, PH1: IDLE->PH0 when the FIFO is non-empty; PH0->PH1 on handshake; PH1->PH0 on handshake if the FIFO still holds another pair after the pop, otherwise PH1->IDLE.
REQ-020 In PH0 dout SHALL be the head din0; in PH1 dout SHALL be the head din1; dout_valid=1 in PH0/PH1, 0 in IDLE; dout_ovf SHALL be the head din_ovf in both phases.
REQ-021 The head pair SHALL be popped on the PH1 handshake only.
REQ-022 dout, dout_valid and dout_ovf SHALL be registered; dout and dout_ovf SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-023 Latency: a pair written at cycle N into an empty FIFO with the FSM in IDLE SHALL appear as din0 at N+1 and, with dout_ready=1, as din1 at N+2.
REQ-024 With din_valid on alternate cycles and dout_ready held at 1, dout_valid SHALL stay high continuously after the first output, with no gaps.
REQ-025 din_valid=1 while the FIFO is full and no pop occurs in that cycle SHALL discard the pair and assert drop for exactly that cycle; the FIFO contents SHALL be unchanged.
REQ-026 ovf_cnt SHALL increment by 1 for each written or dropped pair with din_ovf=1 and SHALL saturate at 2^OVF_CNT_WIDTH-1.
REQ-027 ovf_cnt_clr together with a counting event in the same cycle SHALL load ovf_cnt with 1; ovf_cnt_clr alone SHALL load 0.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the full/empty decision SHALL use a pointer extra bit or the level, never a spare entry.

Reset
REQ-029 While rst=1: FSM=IDLE, FIFO empty, fifo_level=0, dout=0, dout_valid=0, dout_ovf=0, drop=0, ovf_cnt=0.
REQ-030 rst asserted mid-operation SHALL abandon the pair being output, including a pair whose din0 was already accepted; the first cycle after rst deasserts SHALL see dout_valid=0.
REQ-031 din_valid during rst SHALL be ignored and SHALL not count toward ovf_cnt.

Structure
REQ-032 A shared package hb_up2_pkg SHALL hold the FSM state enum (IDLE, PH0, PH1) and the pair struct type {d0, d1, ovf}, parameterized by DATA_WIDTH through the module's typedef.
REQ-033 The pair storage SHALL be one sub-module, sync_fifo, a single-clock FIFO with a width parameter and a depth parameter, push, pop, full, empty and level ports, and registered read data.

Verification
REQ-034 din_valid on alternate cycles, pairs (1,2),(3,4),(5,6), dout_ready=1 -> dout 1,2,3,4,5,6 on consecutive cycles, starting 1 cycle after the first din_valid; drop never asserted.
REQ-035 dout_ready=0 while 5 pairs arrive with FIFO_DEPTH=4 -> fifo_level=4, drop pulses once on the 5th pair; after dout_ready=1 the output is 8 samples of the first 4 pairs, in order.
REQ-036 dout_ready toggling 1,0,1,0 during pair (0x7FFF,0x8000) -> dout holds 0x7FFF until accepted, then 0x8000; no sample repeated or lost.
REQ-037 FIFO full, din_valid coincident with the PH1 handshake -> pair accepted, drop=0, fifo_level stays 4.
REQ-038 din_ovf=1 on 3 pairs, ovf_cnt_clr pulsed with the 3rd -> ovf_cnt=1; with OVF_CNT_WIDTH=2 and 5 ovf pairs -> ovf_cnt=3; dout_ovf=1 on both samples of each flagged pair.
REQ-039 rst pulsed for 1 cycle while in PH1 with 2 pairs queued -> the next cycle shows dout_valid=0 and fifo_level=0, and subsequent pairs are output normally.
